// File: rtl/instruction_loader.sv
// Program loader: assembles big-endian 32-bit words from a byte stream, writes them
// into instruction memory and releases the pipeline once the end-of-program word lands.
module instruction_loader #(
    parameter int unsigned       LENGTH    = 32,
    parameter logic [LENGTH-1:0] END_WORD  = '1,
    parameter int unsigned       MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [LENGTH-1:0] instruction_to_write,
    output logic [LENGTH-1:0] address_to_write,
    output logic              wr_memory_instruction_enable,
    output logic              mips_enable,
    output logic [LENGTH-1:0] loaded_words,
    output logic              load_error
);

    localparam int unsigned       BYTE_W    = 8;
    localparam int unsigned       HOLD_W    = LENGTH - BYTE_W;
    localparam logic [LENGTH-1:0] LAST_IDX  = LENGTH'(MAX_WORDS - 1);
    localparam logic [LENGTH-1:0] ADDR_STEP = LENGTH'(4);
    localparam logic [LENGTH-1:0] ONE       = LENGTH'(1);

    typedef enum logic [1:0] {
        RECEIVE = 2'd0,
        DONE    = 2'd1,
        ERROR   = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [HOLD_W-1:0] hold;
    logic [LENGTH-1:0] addr_cnt;
    logic [LENGTH-1:0] word_c;

    // The first three bytes of a word sit in hold; the fourth completes it combinationally.
    assign word_c = {hold, rx_data};

    // Loader FSM; mips_enable/load_error trail the state by one edge so the last write lands first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                        <= RECEIVE;
            byte_idx                     <= 2'd0;
            hold                         <= '0;
            addr_cnt                     <= '0;
            instruction_to_write         <= '0;
            address_to_write             <= '0;
            wr_memory_instruction_enable <= 1'b0;
            mips_enable                  <= 1'b0;
            loaded_words                 <= '0;
            load_error                   <= 1'b0;
        end else begin
            wr_memory_instruction_enable <= 1'b0;
            mips_enable                  <= (state == DONE);
            load_error                   <= (state == ERROR);

            case (state)
                RECEIVE: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            instruction_to_write         <= word_c;
                            address_to_write             <= addr_cnt;
                            wr_memory_instruction_enable <= 1'b1;
                            loaded_words                 <= loaded_words + ONE;
                            addr_cnt                     <= addr_cnt + ADDR_STEP;
                            // End marker wins even when it fills the last slot.
                            if (word_c == END_WORD) begin
                                state <= DONE;
                            end else if (loaded_words == LAST_IDX) begin
                                state <= ERROR;
                            end
                        end else begin
                            hold <= {hold[HOLD_W-BYTE_W-1:0], rx_data};
                        end
                    end
                end
                DONE:    state <= DONE;
                ERROR:   state <= ERROR;
                default: state <= RECEIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader: three instances (depth 256, 4, 2) checked
// against a word-level reference model of the load stream.
module tb_instruction_loader;

    localparam logic [31:0] END_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst      [3];
    logic [7:0]  rx_data  [3];
    logic        rx_valid [3];
    logic [31:0] instr    [3];
    logic [31:0] addr     [3];
    logic        wr       [3];
    logic        mips     [3];
    logic [31:0] loaded   [3];
    logic        err      [3];

    int checks = 0;
    int errors = 0;

    // reference model state
    int          maxw [3] = '{256, 4, 2};
    logic [7:0]  pend  [3][$];
    logic [63:0] exp_q [3][$];
    logic [63:0] act_q [3][$];
    int          mcount [3];
    bit          mdone  [3];
    bit          merr   [3];

    logic        prev_wr  [3];
    logic        prev_end [3];
    logic        prev_mips[3];
    logic        prev_err [3];

    always #5 clk = ~clk;

    instruction_loader #(.MAX_WORDS(256)) u_main (
        .clk(clk), .reset(rst[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .instruction_to_write(instr[0]), .address_to_write(addr[0]),
        .wr_memory_instruction_enable(wr[0]), .mips_enable(mips[0]),
        .loaded_words(loaded[0]), .load_error(err[0]));

    instruction_loader #(.MAX_WORDS(4)) u_ovf (
        .clk(clk), .reset(rst[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .instruction_to_write(instr[1]), .address_to_write(addr[1]),
        .wr_memory_instruction_enable(wr[1]), .mips_enable(mips[1]),
        .loaded_words(loaded[1]), .load_error(err[1]));

    instruction_loader #(.MAX_WORDS(2)) u_last (
        .clk(clk), .reset(rst[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .instruction_to_write(instr[2]), .address_to_write(addr[2]),
        .wr_memory_instruction_enable(wr[2]), .mips_enable(mips[2]),
        .loaded_words(loaded[2]), .load_error(err[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Collect strobes and check pulse width and the one-edge lag of mips_enable/load_error.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr[i] === 1'b1) begin
                act_q[i].push_back({addr[i], instr[i]});
                check("strobe_width", 64'(prev_wr[i]), 64'd0);
            end
            if (mips[i] === 1'b1 && prev_mips[i] !== 1'b1)
                check("mips_rise", 64'(prev_end[i]), 64'd1);
            if (prev_end[i] === 1'b1)
                check("mips_lat", 64'(mips[i]), 64'd1);
            if (err[i] === 1'b1 && prev_err[i] !== 1'b1)
                check("err_rise", 64'(prev_wr[i]), 64'd1);
            prev_wr[i]   <= wr[i];
            prev_end[i]  <= (wr[i] === 1'b1) && (instr[i] == END_W);
            prev_mips[i] <= mips[i];
            prev_err[i]  <= err[i];
        end
    end

    task automatic model_clear(input int i);
        pend[i].delete();
        exp_q[i].delete();
        act_q[i].delete();
        mcount[i] = 0;
        mdone[i]  = 1'b0;
        merr[i]   = 1'b0;
    endtask

    task automatic send(input int i, input logic [7:0] b, input int gap);
        logic [31:0] w;
        repeat (gap) @(negedge clk);
        rx_data[i]  = b;
        rx_valid[i] = 1'b1;
        if (!mdone[i] && !merr[i]) begin
            pend[i].push_back(b);
            if (pend[i].size() == 4) begin
                w = {pend[i][0], pend[i][1], pend[i][2], pend[i][3]};
                pend[i].delete();
                exp_q[i].push_back({32'(4 * mcount[i]), w});
                mcount[i]++;
                if (w == END_W) mdone[i] = 1'b1;
                else if (mcount[i] == maxw[i]) merr[i] = 1'b1;
            end
        end
        @(negedge clk);
        rx_valid[i] = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [31:0] w, input int maxgap);
        for (int k = 3; k >= 0; k--)
            send(i, w[8*k +: 8], int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
        check("rst_instr", 64'(instr[i]), 64'd0);
        check("rst_addr", 64'(addr[i]), 64'd0);
        check("rst_wr", 64'(wr[i]), 64'd0);
        check("rst_mips", 64'(mips[i]), 64'd0);
        check("rst_loaded", 64'(loaded[i]), 64'd0);
        check("rst_err", 64'(err[i]), 64'd0);
        model_clear(i);
    endtask

    task automatic compare(input int i, input string tag);
        int n;
        repeat (4) @(negedge clk);
        check({tag, "_nwrites"}, 64'(act_q[i].size()), 64'(exp_q[i].size()));
        n = (act_q[i].size() < exp_q[i].size()) ? act_q[i].size() : exp_q[i].size();
        for (int k = 0; k < n; k++)
            check({tag, "_write"}, act_q[i][k], exp_q[i][k]);
        check({tag, "_loaded"}, 64'(loaded[i]), 64'(mcount[i]));
        check({tag, "_mips"}, 64'(mips[i]), 64'(mdone[i]));
        check({tag, "_err"}, 64'(err[i]), 64'(merr[i]));
    endtask

    initial begin
        logic [31:0] w;
        int nw;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            rx_data[i] = 8'h00;
            rx_valid[i] = 1'b0;
            prev_wr[i] = 1'b0;
            prev_end[i] = 1'b0;
            prev_mips[i] = 1'b0;
            prev_err[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) do_reset(i);

        // single word + end, full rate
        send_word(0, 32'h2008_0005, 0);
        send_word(0, END_W, 0);
        compare(0, "single");
        if (act_q[0].size() >= 2) begin
            check("single_w0", act_q[0][0], {32'd0, 32'h2008_0005});
            check("single_w1", act_q[0][1], {32'd4, END_W});
        end

        // ignore bytes after done
        for (int k = 0; k < 8; k++) send(0, 8'($urandom), 0);
        compare(0, "after_done");

        // gapped input
        do_reset(0);
        send_word(0, 32'h2008_0005, 5);
        send_word(0, END_W, 5);
        compare(0, "gapped");

        // reset mid-word
        do_reset(0);
        send(0, 8'hAA, 0);
        send(0, 8'hBB, 0);
        do_reset(0);
        send_word(0, 32'h1122_3344, 0);
        send_word(0, END_W, 0);
        compare(0, "midreset");
        if (act_q[0].size() >= 1)
            check("midreset_w0", act_q[0][0], {32'd0, 32'h1122_3344});

        // random programs with random gaps
        for (int it = 0; it < 6; it++) begin
            do_reset(0);
            nw = int'($urandom_range(1, 12));
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                if (w == END_W) w = 32'h0;
                send_word(0, w, 3);
            end
            send_word(0, END_W, 3);
            for (int k = 0; k < int'($urandom_range(0, 6)); k++) send(0, 8'($urandom), 1);
            compare(0, "random");
        end

        // overflow with a 4-word memory
        for (int k = 0; k < 4; k++) send_word(1, 32'h0, 2);
        for (int k = 0; k < 8; k++) send(1, 8'($urandom), 0);
        compare(1, "overflow");
        check("overflow_err_const", 64'(err[1]), 64'd1);
        check("overflow_mips_const", 64'(mips[1]), 64'd0);
        if (act_q[1].size() == 4)
            check("overflow_last_addr", 64'(act_q[1][3][63:32]), 64'd12);

        // end word in the last slot of a 2-word memory
        send_word(2, 32'h0000_0001, 1);
        send_word(2, END_W, 1);
        compare(2, "last_slot");
        check("last_slot_mips_const", 64'(mips[2]), 64'd1);
        check("last_slot_err_const", 64'(err[2]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
